sa_cache_mem_responder: RTL

// Memory-side responder for the 4-way set-associative cache's miss/refill/evict interface.
// It samples the cache's level miss request and, after a programmable read latency, returns one full line.
// It accepts evicted lines into a single-entry write-back buffer and drains that buffer into a line-organised backing store.
// It sits between the cache and the off-chip memory model; refills and evictions share this one block.

---
 rtl/sa_cache_mem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sa_cache_mem_responder.sv
// Memory-side responder for a set-associative cache: timed line refill plus a
// single-entry write-back buffer that drains evicted lines into the backing store.
module sa_cache_mem_responder #(
  parameter int  LINE_SIZE_BYTES = 4,
  parameter int  ADDRESS_WIDTH   = 32,
  parameter int  MEM_LINES       = 1024,
  parameter int  READ_LATENCY    = 4,
  parameter int  WRITE_LATENCY   = 2,
  localparam int LINE_SIZE_BITS  = 8 * LINE_SIZE_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_cache_miss,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic                      i_evict,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
  output logic [LINE_SIZE_BITS-1:0] o_memory_line,
  output logic                      o_memory_response,
  output logic                      o_busy,
  output logic                      o_wb_overflow,
  output logic [1:0]                fsm_state
);

  localparam int MEM_IDX_BITS = $clog2(MEM_LINES);
  localparam int OFF_BITS     = $clog2(LINE_SIZE_BYTES);
  localparam int RCNT_W       = $clog2(READ_LATENCY + 1);
  localparam int WCNT_W       = $clog2(WRITE_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  // Handshake: the cache raises i_cache_miss (level) and holds it and the address
  // until it sees the one-cycle o_memory_response strobe; the FSM parks in HOLD
  // until the request drops so one miss is never served twice.
  state_t                    state, state_next;
  logic [RCNT_W-1:0]         rcnt, rcnt_next;
  logic                      accept, select;
  logic                      miss_q;
  logic [MEM_IDX_BITS-1:0]   miss_idx, miss_idx_q, line_idx;
  logic [LINE_SIZE_BITS-1:0] rd_data;

  logic                      evict_prev, evict_edge, capture, wb_commit;
  logic                      wb_valid;
  logic [WCNT_W-1:0]         wcnt;
  logic [MEM_IDX_BITS-1:0]   evict_idx, wb_idx;
  logic [LINE_SIZE_BITS-1:0] wb_data;

  logic [LINE_SIZE_BITS-1:0] mem [MEM_LINES];

  // Upper address bits alias onto the same line; only the index field matters.
  logic unused_addr;
  assign unused_addr = ^{i_miss_addr, i_evict_addr};

  assign miss_idx  = i_miss_addr[OFF_BITS +: MEM_IDX_BITS];
  assign evict_idx = i_evict_addr[OFF_BITS +: MEM_IDX_BITS];

  assign evict_edge = i_evict && !evict_prev;
  assign wb_commit  = wb_valid && (wcnt == '0);
  assign capture    = evict_edge && (!wb_valid || wb_commit);

  // Youngest data wins: an eviction landing this cycle, then the buffer, then memory.
  always_comb begin
    rd_data = mem[line_idx];
    if (capture && (evict_idx == line_idx))
      rd_data = i_evict_data;
    else if (wb_valid && (wb_idx == line_idx))
      rd_data = wb_data;
  end

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    accept     = 1'b0;
    select     = 1'b0;
    case (state)
      IDLE: begin
        if (miss_q) begin
          accept     = 1'b1;
          rcnt_next  = RCNT_W'(READ_LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (rcnt == '0) begin
          select     = 1'b1;
          state_next = RESP;
        end else begin
          rcnt_next = rcnt - 1'b1;
        end
      end
      RESP:    state_next = HOLD;
      HOLD:    if (!miss_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rcnt          <= '0;
      miss_q        <= 1'b0;
      miss_idx_q    <= '0;
      line_idx      <= '0;
      o_memory_line <= '0;
    end else begin
      state      <= state_next;
      rcnt       <= rcnt_next;
      miss_q     <= i_cache_miss;
      miss_idx_q <= miss_idx;
      if (accept) line_idx <= miss_idx_q;
      if (select) o_memory_line <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evict_prev    <= 1'b0;
      wb_valid      <= 1'b0;
      wcnt          <= '0;
      wb_idx        <= '0;
      wb_data       <= '0;
      o_wb_overflow <= 1'b0;
    end else begin
      evict_prev <= i_evict;
      if (capture) begin
        wb_valid <= 1'b1;
        wcnt     <= WCNT_W'(WRITE_LATENCY - 1);
        wb_idx   <= evict_idx;
        wb_data  <= i_evict_data;
      end else if (wb_commit) begin
        wb_valid <= 1'b0;
      end else if (wb_valid) begin
        wcnt <= wcnt - 1'b1;
      end
      if (evict_edge && !capture) o_wb_overflow <= 1'b1;
    end
  end

  // Backing store is never cleared; reset only suppresses an in-flight commit.
  always_ff @(posedge clk) begin
    if (!rst && wb_commit) mem[wb_idx] <= wb_data;
  end

  assign o_memory_response = (state == RESP);
  assign o_busy            = (state != IDLE) || wb_valid;
  assign fsm_state         = state;

endmodule
